// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared PS/2 keyboard constants and the controller FSM state type.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_ERR0  = 8'h00;
    localparam logic [7:0] PS2_ERR1  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2,
        EMIT   = 2'd3
    } ps2_state_e;

    // Bytes that carry no key information and reset any pending prefix.
    function automatic logic ps2_is_junk(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Receiver-side byte stream plus key-event handshake of the keyboard controller.
interface ps2_kbd_ctrl_if;

    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_nextdata_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_repeat;
    logic [7:0] press_cnt;

    // Controller side: consumes scan bytes, produces key events.
    modport master (
        input  kbd_data, kbd_ready, ev_ready,
        output kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_repeat, press_cnt
    );

    // Environment side: receiver FIFO and event consumer.
    modport slave (
        output kbd_data, kbd_ready, ev_ready,
        input  kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_repeat, press_cnt
    );

endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0
// prefixes into a single key event and tracks typematic repeats.
module ps2_kbd_ctrl
    import ps2_pkg::*;
(
    input  logic            clk,
    input  logic            clrn,
    ps2_kbd_ctrl_if.master  kbd_bus
);

    ps2_state_e state_q, state_d;
    logic [7:0] byte_q;
    logic       ext_q, brk_q;
    logic [7:0] code_q;
    logic       evext_q, evbrk_q, rep_q;
    logic [8:0] last_q;
    logic       last_v_q;
    logic [7:0] cnt_q;
    logic       pop_n_q, pop_n_d;
    logic       ev_valid;
    logic       hs;

    assign hs = (state_q == EMIT) && kbd_bus.ev_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; kbd_ready is only looked at from IDLE, giving backpressure in EMIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (kbd_bus.kbd_ready) state_d = POP;
            POP:     state_d = DECODE;
            DECODE: begin
                if ((byte_q == PS2_EXT) || (byte_q == PS2_BRK) || ps2_is_junk(byte_q))
                    state_d = IDLE;
                else
                    state_d = EMIT;
            end
            EMIT:    if (kbd_bus.ev_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: event valid in EMIT, pop strobe low while entering/holding POP.
    always_comb begin
        ev_valid = (state_q == EMIT);
        pop_n_d  = (state_d != POP);
    end

    // Registered active-low pop strobe so it is glitch-free toward the receiver.
    always_ff @(posedge clk) begin
        if (!clrn) pop_n_q <= 1'b1;
        else       pop_n_q <= pop_n_d;
    end

    // Byte latch, prefix flags, event fields, last-press memory and press counter.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            byte_q   <= 8'h00;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            code_q   <= 8'h00;
            evext_q  <= 1'b0;
            evbrk_q  <= 1'b0;
            rep_q    <= 1'b0;
            last_q   <= 9'h000;
            last_v_q <= 1'b0;
            cnt_q    <= 8'h00;
        end else begin
            if ((state_q == IDLE) && kbd_bus.kbd_ready)
                byte_q <= kbd_bus.kbd_data;

            if (state_q == DECODE) begin
                if (byte_q == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (byte_q == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else if (ps2_is_junk(byte_q)) begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end else begin
                    code_q  <= byte_q;
                    evext_q <= ext_q;
                    evbrk_q <= brk_q;
                    rep_q   <= !brk_q && last_v_q && ({ext_q, byte_q} == last_q);
                end
            end

            if (hs) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
                if (!evbrk_q) begin
                    last_q   <= {evext_q, code_q};
                    last_v_q <= 1'b1;
                    if (!rep_q) cnt_q <= cnt_q + 8'd1;
                end else if ({evext_q, code_q} == last_q) begin
                    last_v_q <= 1'b0;
                end
            end
        end
    end

    assign kbd_bus.kbd_nextdata_n = pop_n_q;
    assign kbd_bus.ev_valid       = ev_valid;
    assign kbd_bus.ev_code        = code_q;
    assign kbd_bus.ev_ext         = evext_q;
    assign kbd_bus.ev_break       = evbrk_q;
    assign kbd_bus.ev_repeat      = rep_q;
    assign kbd_bus.press_cnt      = cnt_q;

endmodule
